// File: rtl/game_status_counter_pkg.sv
// Shared constants and state encoding for the game status counter and the
// information renderer that draws its HP/time bars.
package game_status_counter_pkg;

   // Bar limits: HP_print counts damage up to HP_MAX, time_print counts steps up to TIME_MAX.
   localparam logic [4:0] HP_MAX   = 5'd9;
   localparam logic [4:0] TIME_MAX = 5'd18;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CLASSIC  = 2'd1,
      INFINITY = 2'd2,
      OVER     = 2'd3
   } game_state_t;

endpackage

// File: rtl/game_status_counter_tick_divider.sv
// Free-running divider that produces a one-cycle tick every TICK_CYCLES
// cycles while run is high; clear forces the count back to zero.
module tick_divider #(
   parameter int TICK_CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   input  logic clear,
   output logic tick
);

   localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(TICK_CYCLES - 1);

   logic [CW-1:0] count;

   // Count 0..TICK_CYCLES-1 while running, wrapping back to zero on the last value.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (run) begin
         if (count == LAST) begin
            count <= '0;
         end else begin
            count <= count + 1'b1;
         end
      end
   end

   // The wrap cycle is the tick; a pending clear suppresses it.
   assign tick = run && !clear && (count == LAST);

endmodule

// File: rtl/game_status_counter.sv
// Player status tracker: counts damage in classic mode and elapsed time steps
// in infinity mode, driving the renderer's bar values and the game-over flags.
module game_status_counter
   import game_status_counter_pkg::*;
#(
   parameter int TICK_CYCLES   = 50_000_000,
   parameter int INVULN_CYCLES = 25_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable_game_classic,
   input  logic       enable_game_infinity,
   input  logic       hit,
   output logic [4:0] HP_print,
   output logic [4:0] time_print,
   output logic       game_over,
   output logic       over_classic
);

   localparam int IW = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
   localparam logic [IW-1:0] INV_LOAD = IW'(INVULN_CYCLES - 1);

   game_state_t   state;
   logic [IW-1:0] inv_count;
   logic          tick;
   logic          tick_run;
   logic          tick_clear;

   assign tick_run   = (state == INFINITY);
   assign tick_clear = (state != INFINITY) || !enable_game_infinity;

   tick_divider #(
      .TICK_CYCLES(TICK_CYCLES)
   ) u_tick_divider (
      .clk  (clk),
      .rst  (rst),
      .run  (tick_run),
      .clear(tick_clear),
      .tick (tick)
   );

   // Mode FSM with registered outputs; every exit to IDLE clears all status.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         HP_print     <= '0;
         time_print   <= '0;
         game_over    <= 1'b0;
         over_classic <= 1'b0;
         inv_count    <= '0;
      end else begin
         case (state)
            IDLE: begin
               HP_print     <= '0;
               time_print   <= '0;
               game_over    <= 1'b0;
               over_classic <= 1'b0;
               inv_count    <= '0;
               if (enable_game_classic) begin
                  state <= CLASSIC;
               end else if (enable_game_infinity) begin
                  state <= INFINITY;
               end
            end
            CLASSIC: begin
               if (!enable_game_classic) begin
                  state      <= IDLE;
                  HP_print   <= '0;
                  time_print <= '0;
                  inv_count  <= '0;
               end else if (hit && (inv_count == '0) && (HP_print != HP_MAX)) begin
                  HP_print  <= HP_print + 5'd1;
                  inv_count <= INV_LOAD;
                  if (HP_print + 5'd1 == HP_MAX) begin
                     state        <= OVER;
                     game_over    <= 1'b1;
                     over_classic <= 1'b1;
                  end
               end else if (inv_count != '0) begin
                  inv_count <= inv_count - 1'b1;
               end
            end
            INFINITY: begin
               if (!enable_game_infinity) begin
                  state      <= IDLE;
                  HP_print   <= '0;
                  time_print <= '0;
                  inv_count  <= '0;
               end else if (tick && (time_print != TIME_MAX)) begin
                  time_print <= time_print + 5'd1;
                  if (time_print + 5'd1 == TIME_MAX) begin
                     state        <= OVER;
                     game_over    <= 1'b1;
                     over_classic <= 1'b0;
                  end
               end
            end
            OVER: begin
               if (!enable_game_classic && !enable_game_infinity) begin
                  state        <= IDLE;
                  HP_print     <= '0;
                  time_print   <= '0;
                  game_over    <= 1'b0;
                  over_classic <= 1'b0;
                  inv_count    <= '0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_game_status_counter.sv
// Self-checking bench for game_status_counter: directed scenarios followed by
// randomized play, every cycle compared against a timestamp-based reference model.
module tb_game_status_counter;

   localparam int TICK   = 3;
   localparam int INVULN = 4;
   localparam int HP_FULL   = 9;
   localparam int TIME_FULL = 18;

   localparam int M_IDLE = 0;
   localparam int M_CLASSIC = 1;
   localparam int M_INFINITY = 2;
   localparam int M_OVER = 3;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enClassic = 1'b0;
   logic       enInfinity = 1'b0;
   logic       hitIn = 1'b0;
   logic [4:0] hpPrint;
   logic [4:0] timePrint;
   logic       gameOver;
   logic       overClassic;

   int compareCount = 0;
   int mismatchCount = 0;

   // Reference model: elapsed-time arithmetic and hit timestamps
   int edgeNo = 0;
   int mMode = M_IDLE;
   int mHp = 0;
   int mTime = 0;
   int mOver = 0;
   int mOverClassic = 0;
   int infStart = 0;
   int lastHitEdge = 0;
   bit hadHit = 1'b0;

   game_status_counter #(
      .TICK_CYCLES(TICK),
      .INVULN_CYCLES(INVULN)
   ) dut (
      .clk(clock),
      .rst(reset),
      .enable_game_classic(enClassic),
      .enable_game_infinity(enInfinity),
      .hit(hitIn),
      .HP_print(hpPrint),
      .time_print(timePrint),
      .game_over(gameOver),
      .over_classic(overClassic)
   );

   always #5 clock = ~clock;

   task checkOutput(input string tag, input int observed, input int expected);
      compareCount++;
      if (observed != expected) begin
         mismatchCount++;
         $display("[TB] FAIL %s at edge %0d: got %0d, expected %0d", tag, edgeNo, observed, expected);
      end
   endtask

   task clearModel();
      mMode = M_IDLE;
      mHp = 0;
      mTime = 0;
      mOver = 0;
      mOverClassic = 0;
      hadHit = 1'b0;
   endtask

   task updateModel();
      if (reset) begin
         clearModel();
      end else begin
         case (mMode)
            M_IDLE: begin
               if (enClassic) begin
                  mMode = M_CLASSIC;
                  hadHit = 1'b0;
               end else if (enInfinity) begin
                  mMode = M_INFINITY;
                  infStart = edgeNo;
               end
            end
            M_CLASSIC: begin
               if (!enClassic) begin
                  clearModel();
               end else if (hitIn && (!hadHit || (edgeNo - lastHitEdge) >= INVULN)) begin
                  mHp++;
                  hadHit = 1'b1;
                  lastHitEdge = edgeNo;
                  if (mHp == HP_FULL) begin
                     mMode = M_OVER;
                     mOver = 1;
                     mOverClassic = 1;
                  end
               end
            end
            M_INFINITY: begin
               if (!enInfinity) begin
                  clearModel();
               end else begin
                  mTime = (edgeNo - infStart) / TICK;
                  if (mTime >= TIME_FULL) begin
                     mTime = TIME_FULL;
                     mMode = M_OVER;
                     mOver = 1;
                     mOverClassic = 0;
                  end
               end
            end
            default: begin
               if (!enClassic && !enInfinity) begin
                  clearModel();
               end
            end
         endcase
      end
   endtask

   task applyStimulus(input logic r, input logic ec, input logic ei, input logic h);
      @(negedge clock);
      reset = r;
      enClassic = ec;
      enInfinity = ei;
      hitIn = h;
      @(posedge clock);
      edgeNo++;
      updateModel();
      #1;
      checkOutput("HP_print", int'(hpPrint), mHp);
      checkOutput("time_print", int'(timePrint), mTime);
      checkOutput("game_over", int'(gameOver), mOver);
      checkOutput("over_classic", int'(overClassic), mOverClassic);
   endtask

   initial begin
      logic rc;
      logic ec;
      logic ei;
      logic hv;
      logic [4:0] invPattern;

      // Reset state
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      checkOutput("reset_hp", int'(hpPrint), 0);
      checkOutput("reset_over", int'(gameOver), 0);

      // Run infinity up to time 7, then reset mid-game
      for (int i = 0; i < 40 && mTime < 7; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      end
      checkOutput("inf_time7", int'(timePrint), 7);
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      checkOutput("midreset_time", int'(timePrint), 0);
      checkOutput("midreset_hp", int'(hpPrint), 0);
      checkOutput("midreset_over", int'(gameOver), 0);

      // Classic damage: 10 hits spaced 5 cycles apart
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      for (int k = 1; k <= 10; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
         checkOutput("hp_step", int'(hpPrint), (k > HP_FULL) ? HP_FULL : k);
         if (k == HP_FULL) begin
            checkOutput("classic_over", int'(gameOver), 1);
            checkOutput("classic_over_cls", int'(overClassic), 1);
         end
         for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
         end
      end
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      checkOutput("over_hold", int'(gameOver), 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput("over_exit", int'(gameOver), 0);
      checkOutput("over_exit_hp", int'(hpPrint), 0);

      // Invulnerability: hits at relative cycles 0, 2, 3, 4
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      invPattern = 5'b11101;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, invPattern[i]);
      end
      checkOutput("invuln_hp", int'(hpPrint), 2);

      // Infinity countdown to exhaustion with stray hits
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 54; i++) begin
         applyStimulus(1'b0, 1'b0, 1'b1, 1'($urandom_range(0, 1)));
      end
      checkOutput("inf_time18", int'(timePrint), TIME_FULL);
      checkOutput("inf_over", int'(gameOver), 1);
      checkOutput("inf_over_cls", int'(overClassic), 0);
      checkOutput("inf_hp", int'(hpPrint), 0);

      // Mode priority and enable loss
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
         for (int j = 0; j < 4; j++) begin
            applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
         end
      end
      checkOutput("prio_hp3", int'(hpPrint), 3);
      checkOutput("prio_time", int'(timePrint), 0);
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
      checkOutput("drop_hp", int'(hpPrint), 0);

      // Randomized play with slowly changing enables
      ec = 1'b0;
      ei = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 39) == 0) ec = ~ec;
         if ($urandom_range(0, 39) == 0) ei = ~ei;
         hv = ($urandom_range(0, 2) == 0);
         rc = ($urandom_range(0, 399) == 0);
         applyStimulus(rc, ec, ei, hv);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
      $finish;
   end

endmodule

// File: doc/game_status_counter.md
# game_status_counter

Tracks player status for the two game modes and produces the bar values consumed by the on-screen information display. In classic mode it counts damage from hit pulses, up to the point of HP exhaustion. In infinity mode it counts elapsed time steps, up to the point of time exhaustion. It sits directly upstream of the information renderer and drives its `HP_print` / `time_print` inputs, plus a game-over flag for the mode controller.

## Interface

Parameters:
- `TICK_CYCLES`, default 50_000_000: clk cycles per time step (1 s at 50 MHz).
- `INVULN_CYCLES`, default 25_000_000: cycles after an accepted hit during which further hits are ignored.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `enable_game_classic`  in  1  classic mode active (level).
- `enable_game_infinity`  in  1  infinity mode active (level).
- `hit`  in  1  one-cycle pulse when the player is struck; already synchronous to `clk`.
- `HP_print`  out  5  damage taken, 0..9; 9 = empty bar.
- `time_print`  out  5  elapsed time steps, 0..18; 18 = empty bar.
- `game_over`  out  1  level, high while in OVER.
- `over_classic`  out  1  level; in OVER, 1 = HP exhausted, 0 = time exhausted.

## Operation

- States: IDLE, CLASSIC, INFINITY, OVER.
- **IDLE:**
  - `HP_print`, `time_print`, tick counter and invulnerability counter are held at 0.
  - Goes to CLASSIC if `enable_game_classic`; otherwise to INFINITY if `enable_game_infinity`.
  - If both enables are high, classic wins.
- **CLASSIC:**
  - An accepted `hit` increments `HP_print` by 1 and loads the invulnerability counter with `INVULN_CYCLES-1`.
  - A `hit` is ignored while that counter is non-zero.
  - When `HP_print` becomes 9, go to OVER with `over_classic`=1.
  - Time is not counted in this state.
- **INFINITY:**
  - The tick counter runs 0..`TICK_CYCLES-1`. On wrap, `time_print` increments by 1.
  - When `time_print` becomes 18, go to OVER with `over_classic`=0.
  - `hit` is ignored.
- **OVER:**
  - All counters and outputs are frozen.
  - Returns to IDLE, clearing everything, only when both enables are low.
- **Enable loss:** from CLASSIC or INFINITY, if the own-mode enable goes low, return to IDLE next cycle and clear.
  - A mode switch therefore always passes through IDLE for at least one cycle.
- **Saturation:** `HP_print` never exceeds 9 and `time_print` never exceeds 18. Both are 5-bit unsigned with no wrap.
- **Reset:** `rst` is honoured in every state, including mid-game and OVER. It overrides all other inputs in the same cycle.

## Timing

- Reset values:
  - state = IDLE
  - `HP_print` = 0, `time_print` = 0
  - `game_over` = 0, `over_classic` = 0
  - internal counters = 0
- All outputs are registered.
- Enable to state change: 1 cycle. An enable sampled high in IDLE at edge N gives state CLASSIC/INFINITY after edge N.
- Hit latency: a `hit` sampled at edge N is visible on `HP_print` after edge N.
  - The 9th accepted hit sets `HP_print`=9 and `game_over`=1 on the same edge.
- Invulnerability: after a hit accepted at edge N, hits at edges N+1..N+`INVULN_CYCLES`-1 are dropped.
  - A hit at edge N+`INVULN_CYCLES` is accepted.
- Time step: the first increment occurs `TICK_CYCLES` edges after entering INFINITY. Further increments follow every `TICK_CYCLES` edges.
- Same-edge conflicts:
  - `hit` on the same edge as enable loss: ignored, and the state clears.
  - Tick wrap on the same edge as enable loss: ignored.

## Structure

- Shared package holds:
  - `HP_MAX` = 9 and `TIME_MAX` = 18.
  - The state encoding (2-bit: IDLE=0, CLASSIC=1, INFINITY=2, OVER=3).
  - The renderer imports the same HP/time maxima so bar segmenting stays consistent.
- One sub-module, `tick_divider`:
  - Parameterised by `TICK_CYCLES`.
  - Inputs: `clk`, `rst`, `run`, `clear`. Output: one-cycle `tick`.
  - Instantiated once for time steps.
- The invulnerability counter is inline.

## Test plan

- **Reset:** assert `rst` mid-INFINITY with `time_print`=7 → the next cycle shows all outputs 0, state IDLE.
- **Classic damage** (`INVULN_CYCLES`=4): 9 hits spaced 5 cycles apart → `HP_print` steps 1..9; `game_over`=1 and `over_classic`=1 on the 9th; a 10th hit leaves `HP_print`=9.
- **Invulnerability** (`INVULN_CYCLES`=4): hits at cycles 0, 2, 3, 4 → `HP_print`=2 (hits at 0 and 4 accepted).
- **Infinity countdown** (`TICK_CYCLES`=3): hold `enable_game_infinity` → `time_print` increments every 3 cycles and reaches 18 after 54 cycles; then `game_over`=1 and `over_classic`=0. `hit` pulses during the run leave `HP_print`=0.
- **Mode priority and exit:** both enables high from IDLE → CLASSIC. Drop classic while `HP_print`=3 → IDLE next cycle, `HP_print`=0. In OVER with one enable still high → stays OVER; both low → IDLE.
